// File: rtl/sar_pkg.sv
// Shared types and sizing helpers for the successive-approximation search controller.
package sar_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    PROBE = 1'b1
  } sar_state_e;

  localparam int SAR_WIDTH = 4;

  // A single-bit search still needs a one-bit index register.
  function automatic int idxWidth(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int SAR_IDX_W = idxWidth(SAR_WIDTH);

endpackage

// File: rtl/sar_trial_gen.sv
// Combinational trial former: sets the bit at position idx on top of the accepted bits.
module sar_trial_gen
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH,
  parameter int IDX_W = idxWidth(SAR_WIDTH)
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [WIDTH-1:0] trial_o
);

  assign trial_o = acc_i | (WIDTH'(1) << idx_i);

endmodule

// File: rtl/sar_search_controller.sv
// Successive-approximation search FSM: probes an external comparator one bit per cycle,
// exiting early on an exact match and flagging non-one-hot verdicts.
module sar_search_controller
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_equal,
  input  logic             cmp_greater,
  input  logic             cmp_less,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int IDX_W = idxWidth(WIDTH);

  sar_state_e       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] newAcc;
  logic [IDX_W-1:0] idxDec;
  logic [WIDTH-1:0] nextTrial;
  logic [2:0]       verdict;

  // A greater verdict means the trial bit belongs in the answer.
  assign newAcc  = cmp_greater ? guess_q : acc_q;
  assign idxDec  = idx_q - IDX_W'(1);
  assign verdict = {cmp_equal, cmp_greater, cmp_less};

  sar_trial_gen #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_trial_gen (
    .acc_i   (newAcc),
    .idx_i   (idxDec),
    .trial_o (nextTrial)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      idx_q    <= '0;
      guess_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      guess_q  <= guess_d;
      result_q <= result_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    guess_d  = guess_q;
    result_d = result_q;
    err_d    = err_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          idx_d   = IDX_W'(WIDTH - 1);
          guess_d = WIDTH'(1) << (WIDTH - 1);
          err_d   = 1'b0;
          state_d = PROBE;
        end
      end
      PROBE: begin
        case (verdict)
          3'b100: begin
            result_d = guess_q;
            done_d   = 1'b1;
            state_d  = IDLE;
          end
          3'b010, 3'b001: begin
            acc_d = newAcc;
            if (idx_q == '0) begin
              result_d = newAcc;
              done_d   = 1'b1;
              state_d  = IDLE;
            end else begin
              idx_d   = idxDec;
              guess_d = nextTrial;
            end
          end
          // Zero or multiple verdict lines: report what was accepted so far.
          default: begin
            err_d    = 1'b1;
            result_d = acc_q;
            done_d   = 1'b1;
            state_d  = IDLE;
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  assign guess  = guess_q;
  assign busy   = (state_q == PROBE);
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_sar_search_controller.sv
// Directed bench: closes the loop with a behavioural comparator that can inject bad verdicts.
module tb_sar_search_controller;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] target;
  logic         injEn;
  logic [2:0]   injVec;
  logic         cmpEqual, cmpGreater, cmpLess;
  logic [W-1:0] guess, result;
  logic         busy, done, err;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] guessLog [0:7];

  always #5 clk = ~clk;

  assign cmpEqual   = injEn ? injVec[2] : (target == guess);
  assign cmpGreater = injEn ? injVec[1] : (target > guess);
  assign cmpLess    = injEn ? injVec[0] : (target < guess);

  sar_search_controller #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cmp_equal   (cmpEqual),
    .cmp_greater (cmpGreater),
    .cmp_less    (cmpLess),
    .guess       (guess),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .err         (err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one edge; returns just after that edge, in the first probe cycle.
  task automatic applyStimulus(input logic [W-1:0] t);
    target = t;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Counts busy cycles and edges until done, logging each trial value.
  task automatic waitDone(output int nProbes, output int edges);
    nProbes = 0;
    edges   = 0;
    while (!done && edges < 20) begin
      if (busy && nProbes < 8) guessLog[nProbes] = guess;
      if (busy) nProbes++;
      tick();
      edges++;
    end
    checkOutput("doneSeen", {31'd0, done}, 32'd1);
  endtask

  initial begin : main
    int n, e;
    rst    = 1'b1;
    start  = 1'b0;
    target = '0;
    injEn  = 1'b0;
    injVec = 3'b000;
    tick();
    tick();
    checkOutput("rstGuess", {28'd0, guess}, 32'd0);
    checkOutput("rstBusy", {31'd0, busy}, 32'd0);
    checkOutput("rstDone", {31'd0, done}, 32'd0);
    checkOutput("rstResult", {28'd0, result}, 32'd0);
    checkOutput("rstErr", {31'd0, err}, 32'd0);
    rst = 1'b0;
    tick();

    // Target 5: trials 8,4,6,5 with the last one an exact match.
    applyStimulus(4'd5);
    checkOutput("t5BusyFirst", {31'd0, busy}, 32'd1);
    waitDone(n, e);
    checkOutput("t5Probes", n, 4);
    checkOutput("t5Edges", e, 4);
    checkOutput("t5G0", {28'd0, guessLog[0]}, 8);
    checkOutput("t5G1", {28'd0, guessLog[1]}, 4);
    checkOutput("t5G2", {28'd0, guessLog[2]}, 6);
    checkOutput("t5G3", {28'd0, guessLog[3]}, 5);
    checkOutput("t5Result", {28'd0, result}, 5);
    checkOutput("t5Err", {31'd0, err}, 0);
    tick();
    checkOutput("t5DonePulse", {31'd0, done}, 0);
    checkOutput("t5ResultHeld", {28'd0, result}, 5);

    // Target 8 matches on the very first probe.
    applyStimulus(4'd8);
    waitDone(n, e);
    checkOutput("t8Probes", n, 1);
    checkOutput("t8Edges", e, 1);
    checkOutput("t8Result", {28'd0, result}, 8);
    tick();

    // Target 0: every probe reports less.
    applyStimulus(4'd0);
    waitDone(n, e);
    checkOutput("t0Probes", n, 4);
    checkOutput("t0G1", {28'd0, guessLog[1]}, 4);
    checkOutput("t0G2", {28'd0, guessLog[2]}, 2);
    checkOutput("t0G3", {28'd0, guessLog[3]}, 1);
    checkOutput("t0Result", {28'd0, result}, 0);
    tick();

    // Target 15: every probe reports greater until the final match.
    applyStimulus(4'd15);
    waitDone(n, e);
    checkOutput("t15Probes", n, 4);
    checkOutput("t15G1", {28'd0, guessLog[1]}, 12);
    checkOutput("t15G2", {28'd0, guessLog[2]}, 14);
    checkOutput("t15G3", {28'd0, guessLog[3]}, 15);
    checkOutput("t15Result", {28'd0, result}, 15);
    tick();

    for (int t = 0; t < 16; t++) begin
      applyStimulus(W'(t));
      waitDone(n, e);
      checkOutput($sformatf("exResult%0d", t), {28'd0, result}, t);
      checkOutput($sformatf("exProbesMax%0d", t), {31'd0, (n <= 4 && n >= 1)}, 1);
    end
    tick();

    // Target 3: first probe (8) is less, second probe gets greater and less together.
    applyStimulus(4'd3);
    tick();
    injEn  = 1'b1;
    injVec = 3'b011;
    tick();
    injEn  = 1'b0;
    checkOutput("illDone", {31'd0, done}, 1);
    checkOutput("illErr", {31'd0, err}, 1);
    checkOutput("illResult", {28'd0, result}, 0);
    checkOutput("illBusy", {31'd0, busy}, 0);
    tick();
    checkOutput("illDoneLow", {31'd0, done}, 0);
    checkOutput("illErrHeld", {31'd0, err}, 1);
    applyStimulus(4'd3);
    checkOutput("illErrCleared", {31'd0, err}, 0);
    waitDone(n, e);
    checkOutput("illRecover", {28'd0, result}, 3);
    tick();

    // Target 2: trials 8,4,2; a start during the first probe must not restart.
    applyStimulus(4'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("busyStartIgnored", {28'd0, guess}, 4);
    tick();
    checkOutput("thirdProbeGuess", {28'd0, guess}, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midRstGuess", {28'd0, guess}, 0);
    checkOutput("midRstBusy", {31'd0, busy}, 0);
    checkOutput("midRstDone", {31'd0, done}, 0);
    checkOutput("midRstResult", {28'd0, result}, 0);
    checkOutput("midRstErr", {31'd0, err}, 0);
    tick();
    checkOutput("midRstNoDone", {31'd0, done}, 0);
    applyStimulus(4'd9);
    waitDone(n, e);
    checkOutput("afterRstResult", {28'd0, result}, 9);
    tick();

    // Back-to-back: second start rides on the done cycle of the first search.
    applyStimulus(4'd6);
    waitDone(n, e);
    checkOutput("b2bFirstResult", {28'd0, result}, 6);
    checkOutput("b2bFirstProbes", n, 3);
    applyStimulus(4'd10);
    checkOutput("b2bSecondBusy", {31'd0, busy}, 1);
    checkOutput("b2bSecondGuess", {28'd0, guess}, 8);
    checkOutput("b2bNoDone", {31'd0, done}, 0);
    waitDone(n, e);
    checkOutput("b2bSecondResult", {28'd0, result}, 10);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sar_search_controller.md
# sar_search_controller

Successive-approximation search controller that discovers an unknown WIDTH-bit target value. It never sees the target directly: it presents trial values to an external magnitude comparator and reads back that comparator's equal/greater/less verdict. It drives the comparator's B operand and consumes its result, so it is the initiator side of the compare interface. Worst-case search time is WIDTH probe cycles, with early exit on an exact match.

## Interface
- WIDTH, 4, operand width in bits; WIDTH >= 1.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begins a search; sampled only in IDLE.
- cmp_equal  input  1  comparator verdict: target == guess.
- cmp_greater  input  1  comparator verdict: target > guess.
- cmp_less  input  1  comparator verdict: target < guess.
- guess  output  WIDTH  registered trial value driven to the comparator.
- busy  output  1  high while in PROBE.
- done  output  1  one-cycle pulse when the search completes.
- result  output  WIDTH  found value; valid from the done cycle and held until the next accepted start.
- err  output  1  set together with done when the verdict is not one-hot; held until the next accepted start.

## Operation
- States:
  - IDLE: waits for start.
  - PROBE: samples one verdict per cycle.
  - No separate DONE state; done is a registered pulse.
- Registers:
  - acc (WIDTH): accepted bits.
  - idx: current bit position, 0..WIDTH-1.
  - guess, result, err.
- Accepted start (IDLE && start), at that edge:
  - acc <= 0.
  - idx <= WIDTH-1.
  - guess <= 1 << (WIDTH-1).
  - err <= 0.
  - Next state is PROBE.
- Each PROBE edge evaluates the current verdict against trial = guess.
  - Verdict not exactly one-hot: err <= 1, result <= acc, done <= 1, go to IDLE.
  - cmp_equal: result <= guess, done <= 1, go to IDLE. This is the early exit.
  - cmp_greater: acc <= guess.
  - cmp_less: acc is unchanged.
  - greater or less with idx == 0: result <= the new acc value, done <= 1, go to IDLE.
  - greater or less with idx > 0: idx <= idx-1, and guess <= new_acc | (1 << (idx-1)).
- Ignored inputs:
  - start while busy has no effect.
  - Comparator inputs are don't-care in IDLE.
- guess holds its last value in IDLE.
- done is high for exactly one cycle per search and is low in every other cycle.

## Timing
- Reset value of every output: guess = 0, busy = 0, done = 0, result = 0, err = 0. State is IDLE, acc = 0, idx = 0.
- A rst asserted mid-search wins over all other activity: the next state is IDLE, no done pulse is produced, and result is cleared.
- The comparator is combinational. Its verdict for the current guess is sampled at the next rising edge, so there is one probe per cycle.
- Latency:
  - Start sampled at edge E0; the first probe cycle follows E0.
  - A search that finishes after n probes (1 <= n <= WIDTH) has done high in the cycle following edge E0+n.
  - busy is high for exactly n cycles.
- A new start is accepted in the same cycle that done is high, because the state is already IDLE.
- Back-to-back searches are therefore possible with zero idle cycles between them.
- Boundary cases:
  - target 0: all probes return less, n = WIDTH, result = 0.
  - target 2^WIDTH-1: the last probe is equal, n = WIDTH.
  - target 2^(WIDTH-1): n = 1.

## Structure
- Shared package sar_pkg holds:
  - the state enum (IDLE, PROBE);
  - the default WIDTH constant;
  - a localparam for the idx width, $clog2(WIDTH) with a minimum of 1.
- One sub-module, sar_trial_gen, is combinational. It maps (acc, idx) to acc | onehot(idx) and is used to form the next guess.
- The FSM and all registers live in sar_search_controller.
- The bench closes the loop with a behavioural comparator, target vs guess, that can also inject illegal verdicts.

## Test plan
All scenarios use WIDTH = 4.
- Target 5: guesses 8, 4, 6, 5; verdicts less, greater, less, equal. Response: result = 5, n = 4, err = 0.
- Target 8: guess 8 returns equal. Response: done two cycles after the start edge, busy high for 1 cycle, result = 8.
- Target 0 and target 15:
  - Target 0: guesses 8, 4, 2, 1, all less. Response: result = 0.
  - Target 15: guesses 8, 12, 14, 15. Response: result = 15.
  - Exhaustive loop over targets 0..15: result == target, and n <= 4 in every case.
- Illegal verdict: force greater and less together on the second probe. Response: err = 1 and done pulse; acc at that point is 0 for target 3, so result = 0. The next start clears err.
- Start while busy, then rst on the third probe cycle:
  - start pulsed while busy: ignored.
  - rst on the third probe cycle: next cycle all outputs are 0 and no done pulse occurs.
  - Afterwards a fresh start with target 9 gives result = 9.
- Back-to-back: start asserted during the done cycle of a target-6 search, second target 10. Response: second search begins immediately; results 6 then 10.
